// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds the FSM encoding, access-width codes and the default timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_MA = 2'd1,
        S_BUSY_IF = 2'd2,
        S_RESP    = 2'd3
    } arb_state_t;

    localparam logic [2:0] MEM_W_BYTE = 3'b000;
    localparam logic [2:0] MEM_W_HALF = 3'b001;
    localparam logic [2:0] MEM_W_WORD = 3'b010;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data-access and memory-port signals around the arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        ma_req;
    logic        ma_we;
    logic [2:0]  ma_width;
    logic [31:0] ma_addr;
    logic [31:0] ma_wdata;
    logic [31:0] ma_rdata;
    logic        ma_done;

    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        stall;
    logic        timeout_err;

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  ma_req, ma_we, ma_width, ma_addr, ma_wdata,
        input  mem_ack, mem_rdata,
        output if_rdata, if_done, ma_rdata, ma_done,
        output mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        output stall, timeout_err
    );

    modport master (
        output if_req, if_addr, if_cancel,
        output ma_req, ma_we, ma_width, ma_addr, ma_wdata,
        output mem_ack, mem_rdata,
        input  if_rdata, if_done, ma_rdata, ma_done,
        input  mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        input  stall, timeout_err
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter used to abort a hung memory transaction.
// Only exists when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    // Count cycles while enabled; restart whenever cleared.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    // Fires during the LIMIT-th enabled cycle.
    assign expired = enable && (cnt == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-access requests onto one memory port.
// Optional busy timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    arb_state_t  state, state_n;
    logic        grant_ma;
    logic        cancel_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [2:0]  mem_width_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_buf;
    logic [31:0] if_rdata_q;
    logic [31:0] ma_rdata_q;

    logic busy;
    logic expired;
    logic tmo_hit;
    logic in_if;
    logic cancel_any;
    logic if_done_c;
    logic ma_done_c;
    logic busy_n;

    assign busy    = (state == S_BUSY_MA) || (state == S_BUSY_IF);
    assign tmo_hit = busy && expired && !bus.mem_ack;

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_q;

    mem_arb_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!busy),
        .enable (busy),
        .expired(expired)
    );

    // Sticky record that some transaction was aborted.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign expired         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus response qualifiers; MA wins ties in IDLE.
    always_comb begin
        state_n    = state;
        busy_n     = 1'b0;
        in_if      = 1'b0;
        cancel_any = 1'b0;
        if_done_c  = 1'b0;
        ma_done_c  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.ma_req) begin
                    state_n = S_BUSY_MA;
                end else if (bus.if_req) begin
                    state_n = S_BUSY_IF;
                end
            end
            S_BUSY_MA, S_BUSY_IF: begin
                if (bus.mem_ack || expired) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n     = (state_n == S_BUSY_MA) || (state_n == S_BUSY_IF);
        in_if      = (state == S_BUSY_IF) || ((state == S_RESP) && !grant_ma);
        cancel_any = in_if && (cancel_q || bus.if_cancel);
        if_done_c  = (state == S_RESP) && !grant_ma && !cancel_any;
        ma_done_c  = (state == S_RESP) && grant_ma;
    end

    // Command capture on grant, read data capture on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_ma    <= 1'b0;
            cancel_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_width_q <= 3'b000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata_buf   <= 32'h0;
            if_rdata_q  <= 32'h0;
            ma_rdata_q  <= 32'h0;
        end else begin
            mem_req_q <= busy_n;
            if ((state == S_IDLE) && busy_n) begin
                grant_ma <= (state_n == S_BUSY_MA);
                if (state_n == S_BUSY_MA) begin
                    mem_we_q    <= bus.ma_we;
                    mem_width_q <= bus.ma_width;
                    mem_addr_q  <= bus.ma_addr;
                    mem_wdata_q <= bus.ma_wdata;
                end else begin
                    mem_we_q    <= 1'b0;
                    mem_width_q <= MEM_W_WORD;
                    mem_addr_q  <= bus.if_addr;
                end
            end
            if (busy && (state_n == S_RESP)) begin
                rdata_buf <= tmo_hit ? 32'h0 : bus.mem_rdata;
                if (grant_ma) begin
                    ma_rdata_q <= tmo_hit ? 32'h0 : bus.mem_rdata;
                end
            end
            if (state == S_RESP) begin
                cancel_q <= 1'b0;
            end else if ((state == S_BUSY_IF) && bus.if_cancel) begin
                cancel_q <= 1'b1;
            end
            if (if_done_c) begin
                if_rdata_q <= rdata_buf;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_width = mem_width_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_c;
    assign bus.ma_done   = ma_done_c;
    assign bus.if_rdata  = if_done_c ? rdata_buf : if_rdata_q;
    assign bus.ma_rdata  = ma_rdata_q;
    assign bus.stall     = (bus.ma_req && !ma_done_c) ||
                           (bus.if_req && !if_done_c);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change on the falling edge; outputs are checked there too.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   n_if_done;
    int   n_ma_done;
    int   ifd0;
    int   mad0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count completion pulses as the DUT's own edge sees them.
    always @(posedge clk) begin
        if (bus.if_done) n_if_done++;
        if (bus.ma_done) n_ma_done++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_if_done = 0;
        n_ma_done = 0;
        reset     = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.if_cancel = 1'b0;
        bus.ma_req    = 1'b0;
        bus.ma_we     = 1'b0;
        bus.ma_width  = MEM_W_BYTE;
        bus.ma_addr   = 32'h0;
        bus.ma_wdata  = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (3) cyc();

        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_if_done", 32'(bus.if_done), 32'd0);
        check("rst_ma_done", 32'(bus.ma_done), 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_ma_rdata", bus.ma_rdata, 32'h0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_tmo", 32'(bus.timeout_err), 32'd0);
        reset = 1'b0;
        cyc();

        // Fetch with ack two cycles after mem_req.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        cyc();
        check("a_req", 32'(bus.mem_req), 32'd1);
        check("a_we", 32'(bus.mem_we), 32'd0);
        check("a_width", 32'(bus.mem_width), 32'd2);
        check("a_addr", bus.mem_addr, 32'h100);
        check("a_stall", 32'(bus.stall), 32'd1);
        cyc();
        check("a_wait_req", 32'(bus.mem_req), 32'd1);
        check("a_wait_done", 32'(bus.if_done), 32'd0);
        cyc();
        check("a_req3", 32'(bus.mem_req), 32'd1);
        check("a_stall3", 32'(bus.stall), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00500093;
        cyc();
        check("a_done", 32'(bus.if_done), 32'd1);
        check("a_rdata", bus.if_rdata, 32'h00500093);
        check("a_stall_rel", 32'(bus.stall), 32'd0);
        check("a_req_low", 32'(bus.mem_req), 32'd0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFFFFFF;
        bus.if_req    = 1'b0;
        cyc();
        check("a_pulse", 32'(bus.if_done), 32'd0);
        check("a_hold", bus.if_rdata, 32'h00500093);

        // Simultaneous requests: MA first, then IF.
        ifd0 = n_if_done;
        mad0 = n_ma_done;
        bus.ma_req   = 1'b1;
        bus.ma_we    = 1'b1;
        bus.ma_width = MEM_W_WORD;
        bus.ma_addr  = 32'h2000;
        bus.ma_wdata = 32'hDEADBEEF;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h300;
        cyc();
        check("b_ma_addr", bus.mem_addr, 32'h2000);
        check("b_ma_we", 32'(bus.mem_we), 32'd1);
        check("b_ma_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("b_ma_width", 32'(bus.mem_width), 32'd2);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0;
        cyc();
        check("b_ma_done", 32'(bus.ma_done), 32'd1);
        check("b_if_wait", 32'(bus.if_done), 32'd0);
        check("b_stall_if", 32'(bus.stall), 32'd1);
        bus.mem_ack = 1'b0;
        bus.ma_req  = 1'b0;
        bus.ma_we   = 1'b0;
        cyc();
        check("b_idle_gap", 32'(bus.mem_req), 32'd0);
        cyc();
        check("b_if_req", 32'(bus.mem_req), 32'd1);
        check("b_if_addr", bus.mem_addr, 32'h300);
        check("b_if_we", 32'(bus.mem_we), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h11112222;
        cyc();
        check("b_if_done", 32'(bus.if_done), 32'd1);
        check("b_if_rdata", bus.if_rdata, 32'h11112222);
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        cyc();
        check("b_one_if", 32'(n_if_done - ifd0), 32'd1);
        check("b_one_ma", 32'(n_ma_done - mad0), 32'd1);

        // Cancel during BUSY_IF.
        ifd0 = n_if_done;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        cyc();
        check("c_addr", bus.mem_addr, 32'h104);
        bus.if_cancel = 1'b1;
        cyc();
        check("c_busy", 32'(bus.mem_req), 32'd1);
        bus.if_cancel = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        cyc();
        check("c_no_done", 32'(bus.if_done), 32'd0);
        check("c_rdata", bus.if_rdata, 32'h11112222);
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        cyc();
        check("c_idle", 32'(bus.mem_req), 32'd0);
        check("c_rdata_keep", bus.if_rdata, 32'h11112222);
        cyc();
        check("c_no_restart", 32'(bus.mem_req), 32'd0);
        check("c_cnt", 32'(n_if_done - ifd0), 32'd0);

        // Cancel arriving in the RESP cycle.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h108;
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h9ABCDEF0;
        cyc();
        bus.mem_ack   = 1'b0;
        bus.if_cancel = 1'b1;
        #1;
        check("c2_no_done", 32'(bus.if_done), 32'd0);
        check("c2_rdata", bus.if_rdata, 32'h11112222);
        cyc();
        bus.if_cancel = 1'b0;
        bus.if_req    = 1'b0;
        cyc();
        check("c2_keep", bus.if_rdata, 32'h11112222);

        // Back-to-back MA reads with req held through RESP.
        bus.ma_req   = 1'b1;
        bus.ma_we    = 1'b0;
        bus.ma_width = MEM_W_BYTE;
        bus.ma_addr  = 32'h40;
        cyc();
        check("d_width", 32'(bus.mem_width), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        cyc();
        check("d_done", 32'(bus.ma_done), 32'd1);
        check("d_rdata", bus.ma_rdata, 32'hCAFEF00D);
        check("d_resp_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;
        bus.ma_addr = 32'h44;
        cyc();
        check("d_idle_req", 32'(bus.mem_req), 32'd0);
        check("d_idle_done", 32'(bus.ma_done), 32'd0);
        cyc();
        check("d_req2", 32'(bus.mem_req), 32'd1);
        check("d_addr2", bus.mem_addr, 32'h44);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        cyc();
        check("d_done2", 32'(bus.ma_done), 32'd1);
        check("d_rdata2", bus.ma_rdata, 32'h0BADF00D);
        bus.mem_ack = 1'b0;
        bus.ma_req  = 1'b0;
        cyc();

        // MA request that memory never acknowledges.
        bus.ma_req   = 1'b1;
        bus.ma_width = MEM_W_HALF;
        bus.ma_addr  = 32'h90;
        cyc();
        check("f_req", 32'(bus.mem_req), 32'd1);
        repeat (3) cyc();
        check("f_busy4", 32'(bus.mem_req), 32'd1);
        check("f_nodone4", 32'(bus.ma_done), 32'd0);
        cyc();
`ifdef MEM_ARB_TIMEOUT_EN
        check("f_to_done", 32'(bus.ma_done), 32'd1);
        check("f_to_rdata", bus.ma_rdata, 32'h0);
        check("f_to_err", 32'(bus.timeout_err), 32'd1);
        bus.ma_req = 1'b0;
        cyc();
        check("f_err_hold", 32'(bus.timeout_err), 32'd1);
        check("f_req_low", 32'(bus.mem_req), 32'd0);
        cyc();
        check("f_err_hold2", 32'(bus.timeout_err), 32'd1);
`else
        check("f_wait", 32'(bus.mem_req), 32'd1);
        check("f_nodone", 32'(bus.ma_done), 32'd0);
        check("f_no_err", 32'(bus.timeout_err), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00007777;
        cyc();
        check("f_done", 32'(bus.ma_done), 32'd1);
        check("f_rdata", bus.ma_rdata, 32'h00007777);
        bus.mem_ack = 1'b0;
        bus.ma_req  = 1'b0;
        cyc();
`endif

        // Reset mid-transaction, then a stray ack.
        bus.ma_req   = 1'b1;
        bus.ma_width = MEM_W_WORD;
        bus.ma_addr  = 32'h80;
        cyc();
        check("g_req", 32'(bus.mem_req), 32'd1);
        cyc();
        reset = 1'b1;
        cyc();
        check("g_rst_req", 32'(bus.mem_req), 32'd0);
        check("g_rst_done", 32'(bus.ma_done), 32'd0);
        check("g_rst_err", 32'(bus.timeout_err), 32'd0);
        reset         = 1'b0;
        bus.ma_req    = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h55;
        cyc();
        check("g_stray_req", 32'(bus.mem_req), 32'd0);
        check("g_stray_done", 32'(bus.ma_done), 32'd0);
        bus.mem_ack = 1'b0;
        cyc();
        check("g_idle_req", 32'(bus.mem_req), 32'd0);
        check("g_idle_done", 32'(bus.ma_done), 32'd0);
        check("g_rdata_clr", bus.ma_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max busy cycles before abort (timeout build only).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 if_req / if_addr / if_cancel  in  1/32/1  fetch read request, word address, redirect cancel.
REQ-005 if_rdata / if_done  out  32/1  fetch data, one-cycle completion pulse.
REQ-006 ma_req / ma_we / ma_width / ma_addr / ma_wdata  in  1/1/3/32/32  data-access request (memacc encoding).
REQ-007 ma_rdata / ma_done  out  32/1  data-access read data, one-cycle completion pulse.
REQ-008 mem_req / mem_we / mem_width / mem_addr / mem_wdata  out  1/1/3/32/32  unified memory port command.
REQ-009 mem_ack / mem_rdata  in  1/32  memory completion, read data valid with ack.
REQ-010 stall  out  1  pipeline-wide stall to all five stages.
REQ-011 timeout_err  out  1  sticky timeout flag.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY_MA, BUSY_IF, RESP.
- IDLE: ma_req -> BUSY_MA; else if_req -> BUSY_IF; else stay.
- BUSY_x: mem_ack -> RESP; else stay.
- RESP: -> IDLE unconditionally; requests ignored.
REQ-013 Simultaneous ma_req and if_req in IDLE SHALL grant MA (older instruction first); IF is served on the next IDLE.
REQ-014 Command outputs SHALL be registered: captured on the IDLE->BUSY edge and held stable until the mem_ack cycle. mem_req = 1 exactly in BUSY states.
REQ-015 The IF grant SHALL drive mem_we=0 and mem_width=3'b010 (word). The MA grant SHALL pass ma_we, ma_width, and ma_wdata verbatim.
REQ-016 mem_rdata SHALL be captured on the mem_ack edge into the granted requester's rdata register, held until that requester's next completion, with no byte extraction.
REQ-017 The x_done pulse for the granted requester SHALL be asserted during RESP for exactly one cycle.
REQ-018 Minimum latency: request seen at cycle 0, mem_req at cycle 1, ack at cycle k≥1, done at cycle k+1, IDLE at cycle k+2.
REQ-019 mem_ack outside BUSY states SHALL be ignored.
REQ-020 Requesters hold req and operands stable until done; req still high in the RESP cycle SHALL NOT restart a transaction.
REQ-021 stall = (ma_req & ~ma_done) | (if_req & ~if_done), combinational.
REQ-022 if_cancel asserted in BUSY_IF or RESP(IF) SHALL suppress if_done and leave if_rdata unchanged. The memory transaction runs to ack; the cancel is latched until RESP exits.
REQ-023 if_cancel SHALL have no effect during MA grants or IDLE.

Reset
REQ-024 Reset SHALL force state=IDLE and clear mem_req, mem_we, if_done, ma_done, timeout_err, the cancel flag, and the timer. Command, data, and rdata registers SHALL reset to 0.
REQ-025 Reset mid-transaction SHALL abandon the grant; a later stray mem_ack is ignored per REQ-019.

Configuration
REQ-026 Macro MEM_ARB_TIMEOUT_EN, when defined:
- a counter SHALL count cycles spent in BUSY states;
- at count == TIMEOUT_CYCLES without ack, the FSM SHALL go to RESP, pulse the granted done with rdata=0, and set timeout_err (sticky until reset).
REQ-027 Without MEM_ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely, timeout_err SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-028 Package mem_arb_pkg SHALL hold:
- the FSM state encoding;
- width constants MEM_W_BYTE=3'b000, MEM_W_HALF=3'b001, MEM_W_WORD=3'b010;
- the default TIMEOUT_CYCLES.
REQ-029 The timeout counter SHALL be sub-module mem_arb_timer (clear/enable/expired), instantiated only under MEM_ARB_TIMEOUT_EN. The FSM stays in mem_arbiter.

Verification
REQ-030 if_req=1, if_addr=0x100, ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_we=0, mem_width=010, if_done one cycle with if_rdata=0x00500093, stall high until that cycle.
REQ-031 if_req and ma_req(we=1, addr=0x2000, wdata=0xDEADBEEF, width=010) same cycle -> MA command first, then IF command after RESP+IDLE; exactly one done each.
REQ-032 if_req at 0x104, if_cancel pulsed in the BUSY_IF cycle, ack returns 0x12345678 -> no if_done, if_rdata unchanged, FSM returns to IDLE.
REQ-033 ma_req read issued, reset asserted mid-BUSY, ack arrives 1 cycle after reset -> mem_req=0, no ma_done, state IDLE.
REQ-034 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ma_req and never ack -> ma_done with ma_rdata=0 after 4 busy cycles, timeout_err=1 held until reset.
REQ-035 Back-to-back ma_req held through RESP -> no second mem_req until the IDLE cycle following RESP.
